tmr_scrub_ctrl: RTL and testbench

Sequencing and arbitration controller for the triple-redundant RAM (three identical BITS-wide blocks A/B/C written in parallel, read through the majority voter). Serves single-word host reads/writes and runs a background scrubber that periodically reads every address, votes, and writes the corrected word back to all three blocks whenever any bit disagreed. Sits between the IHU bus interface and the three RAM blocks; keeps the error count used for telemetry.

---
 rtl/tmr_scrub_ctrl_pkg.sv | 20 ++
 rtl/tmr_scrub_ctrl_edac.sv | 15 +
 rtl/tmr_scrub_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_tmr_scrub_ctrl.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tmr_scrub_ctrl_pkg.sv
// Shared types and constants for the TMR RAM scrub controller.
package tmr_scrub_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_CHK  = 2'd2,
        ST_WB   = 2'd3
    } state_e;

    localparam int ERR_W = 8;
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    function automatic logic [ERR_W-1:0] sat_inc(
        input logic [ERR_W-1:0] v
    );
        return (v == ERR_MAX) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/tmr_scrub_ctrl_edac.sv
// Bitwise majority voter over the three RAM blocks with mismatch flag.
module tmr_scrub_ctrl_edac #(
    parameter int BITS = 8
) (
    input  logic [BITS-1:0] DIA,
    input  logic [BITS-1:0] DIB,
    input  logic [BITS-1:0] DIC,
    output logic [BITS-1:0] DO,
    output logic            ERR_DET_C
);

    assign DO = (DIA & DIB) | (DIA & DIC) | (DIB & DIC);
    assign ERR_DET_C = |((DIA ^ DIB) | (DIA ^ DIC));

endmodule

// File: rtl/tmr_scrub_ctrl.sv
// Host/scrub arbiter and sequencer for the triple-redundant RAM.
module tmr_scrub_ctrl
    import tmr_scrub_ctrl_pkg::*;
#(
    parameter int BITS      = 8,
    parameter int ABITS     = 10,
    parameter int SCRUB_DIV = 1024
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             HREQ,
    input  logic             HWE,
    input  logic [ABITS-1:0] HADDR,
    input  logic [BITS-1:0]  HWDATA,
    output logic [BITS-1:0]  HRDATA,
    output logic             HACK,
    output logic [ABITS-1:0] RADDR,
    output logic             RWE,
    output logic [BITS-1:0]  RWDATA,
    input  logic [BITS-1:0]  EDIA,
    input  logic [BITS-1:0]  EDIB,
    input  logic [BITS-1:0]  EDIC,
    input  logic             SCRUB_EN,
    input  logic             ERR_CLR,
    output logic [ERR_W-1:0] ERR_CNT,
    output logic             ERR_PULSE,
    output logic             SCRUB_WRAP
);

    localparam int TW = (SCRUB_DIV > 1) ? $clog2(SCRUB_DIV) : 1;
    localparam logic [TW-1:0] TICK_MAX = TW'(SCRUB_DIV - 1);

    state_e state_q, state_d;
    logic host_q, host_d;
    logic last_host_q, last_host_d;
    logic [TW-1:0] tick_q, tick_d;
    logic pend_q, pend_d;
    logic [ABITS-1:0] saddr_q, saddr_d;
    logic [ABITS-1:0] raddr_q, raddr_d;
    logic [BITS-1:0] rwdata_q, rwdata_d;
    logic [BITS-1:0] hrdata_q, hrdata_d;
    logic rwe_q, rwe_d;
    logic hack_q, hack_d;
    logic epulse_q, epulse_d;
    logic wrap_q, wrap_d;
    logic [ERR_W-1:0] errcnt_q, errcnt_d;

    logic [BITS-1:0] vdo;
    logic verr;
    logic host_req;
    logic grant_s;
    logic step_done;
    logic err_inc;
    logic tc;

    tmr_scrub_ctrl_edac #(
        .BITS(BITS)
    ) u_edac (
        .DIA      (EDIA),
        .DIB      (EDIB),
        .DIC      (EDIC),
        .DO       (vdo),
        .ERR_DET_C(verr)
    );

    // HREQ is still high during its own HACK cycle, so it is masked there
    assign host_req = HREQ && !hack_q;

    always_comb begin
        state_d     = state_q;
        host_d      = host_q;
        last_host_d = last_host_q;
        raddr_d     = raddr_q;
        rwdata_d    = rwdata_q;
        hrdata_d    = hrdata_q;
        rwe_d       = 1'b0;
        hack_d      = 1'b0;
        epulse_d    = 1'b0;
        wrap_d      = 1'b0;
        saddr_d     = saddr_q;
        grant_s     = 1'b0;
        step_done   = 1'b0;
        err_inc     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (host_req && !(pend_q && last_host_q)) begin
                    state_d     = ST_ACC;
                    host_d      = 1'b1;
                    last_host_d = 1'b1;
                    raddr_d     = HADDR;
                    rwe_d       = HWE;
                    rwdata_d    = HWDATA;
                end else if (pend_q) begin
                    state_d     = ST_ACC;
                    host_d      = 1'b0;
                    last_host_d = 1'b0;
                    raddr_d     = saddr_q;
                    grant_s     = 1'b1;
                end
            end
            ST_ACC: begin
                if (rwe_q) begin
                    state_d = ST_IDLE;
                    hack_d  = 1'b1;
                end else begin
                    state_d = ST_CHK;
                end
            end
            ST_CHK: begin
                if (host_q) begin
                    hrdata_d = vdo;
                    hack_d   = 1'b1;
                end
                if (verr) begin
                    state_d  = ST_WB;
                    rwe_d    = 1'b1;
                    rwdata_d = vdo;
                    epulse_d = 1'b1;
                    err_inc  = 1'b1;
                end else begin
                    state_d   = ST_IDLE;
                    step_done = !host_q;
                end
            end
            ST_WB: begin
                state_d   = ST_IDLE;
                step_done = !host_q;
            end
            default: state_d = ST_IDLE;
        endcase
        if (step_done) begin
            saddr_d = saddr_q + 1'b1;
            wrap_d  = &saddr_q;
        end
    end

    always_comb begin
        if (ERR_CLR) begin
            errcnt_d = '0;
        end else if (err_inc) begin
            errcnt_d = sat_inc(errcnt_q);
        end else begin
            errcnt_d = errcnt_q;
        end
    end

    // A terminal tick while already pending is absorbed, never queued
    always_comb begin
        tc = (tick_q == TICK_MAX);
        if (!SCRUB_EN) begin
            tick_d = '0;
            pend_d = 1'b0;
        end else begin
            tick_d = tc ? '0 : tick_q + 1'b1;
            pend_d = grant_s ? 1'b0 : (tc ? 1'b1 : pend_q);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            host_q      <= 1'b0;
            last_host_q <= 1'b0;
            tick_q      <= '0;
            pend_q      <= 1'b0;
            saddr_q     <= '0;
            raddr_q     <= '0;
            rwdata_q    <= '0;
            hrdata_q    <= '0;
            rwe_q       <= 1'b0;
            hack_q      <= 1'b0;
            epulse_q    <= 1'b0;
            wrap_q      <= 1'b0;
            errcnt_q    <= '0;
        end else begin
            state_q     <= state_d;
            host_q      <= host_d;
            last_host_q <= last_host_d;
            tick_q      <= tick_d;
            pend_q      <= pend_d;
            saddr_q     <= saddr_d;
            raddr_q     <= raddr_d;
            rwdata_q    <= rwdata_d;
            hrdata_q    <= hrdata_d;
            rwe_q       <= rwe_d;
            hack_q      <= hack_d;
            epulse_q    <= epulse_d;
            wrap_q      <= wrap_d;
            errcnt_q    <= errcnt_d;
        end
    end

    assign HRDATA     = hrdata_q;
    assign HACK       = hack_q;
    assign RADDR      = raddr_q;
    assign RWE        = rwe_q;
    assign RWDATA     = rwdata_q;
    assign ERR_CNT    = errcnt_q;
    assign ERR_PULSE  = epulse_q;
    assign SCRUB_WRAP = wrap_q;

endmodule

// File: tb/tb_tmr_scrub_ctrl.sv
// Bench for tmr_scrub_ctrl: behavioural RAM plus golden-content model.
module tb_tmr_scrub_ctrl;

    localparam int BITS = 8;
    localparam int ABITS = 5;
    localparam int DIV = 4;
    localparam int N = 1 << ABITS;

    logic CLK = 1'b0;
    logic RST;
    logic HREQ;
    logic HWE;
    logic [ABITS-1:0] HADDR;
    logic [BITS-1:0] HWDATA;
    logic [BITS-1:0] HRDATA;
    logic HACK;
    logic [ABITS-1:0] RADDR;
    logic RWE;
    logic [BITS-1:0] RWDATA;
    logic [BITS-1:0] EDIA, EDIB, EDIC;
    logic SCRUB_EN;
    logic ERR_CLR;
    logic [7:0] ERR_CNT;
    logic ERR_PULSE;
    logic SCRUB_WRAP;

    int checks = 0;
    int errors = 0;

    logic [BITS-1:0] memA [N];
    logic [BITS-1:0] memB [N];
    logic [BITS-1:0] memC [N];
    logic inj;
    logic [1:0] inj_blk;
    logic [ABITS-1:0] inj_a;
    logic [BITS-1:0] inj_v;

    logic [BITS-1:0] golden [N];
    int errcnt_exp;

    tmr_scrub_ctrl #(
        .BITS(BITS), .ABITS(ABITS), .SCRUB_DIV(DIV)
    ) dut (
        .CLK(CLK), .RST(RST), .HREQ(HREQ), .HWE(HWE),
        .HADDR(HADDR), .HWDATA(HWDATA), .HRDATA(HRDATA),
        .HACK(HACK), .RADDR(RADDR), .RWE(RWE),
        .RWDATA(RWDATA), .EDIA(EDIA), .EDIB(EDIB),
        .EDIC(EDIC), .SCRUB_EN(SCRUB_EN), .ERR_CLR(ERR_CLR),
        .ERR_CNT(ERR_CNT), .ERR_PULSE(ERR_PULSE),
        .SCRUB_WRAP(SCRUB_WRAP)
    );

    always #5 CLK = ~CLK;

    // Synchronous RAM triplet; inj lets the bench plant/restore contents
    always @(posedge CLK) begin
        if (inj) begin
            if (inj_blk == 2'd0 || inj_blk == 2'd3) memA[inj_a] <= inj_v;
            if (inj_blk == 2'd1 || inj_blk == 2'd3) memB[inj_a] <= inj_v;
            if (inj_blk == 2'd2 || inj_blk == 2'd3) memC[inj_a] <= inj_v;
        end else if (RWE) begin
            memA[RADDR] <= RWDATA;
            memB[RADDR] <= RWDATA;
            memC[RADDR] <= RWDATA;
        end
        EDIA <= memA[RADDR];
        EDIB <= memB[RADDR];
        EDIC <= memC[RADDR];
    end

    function automatic int err_step(input int v);
        return (v < 255) ? v + 1 : 255;
    endfunction

    task automatic corrupt(input logic [1:0] blk, input logic [ABITS-1:0] a,
                           input logic [BITS-1:0] v);
        inj = 1'b1; inj_blk = blk; inj_a = a; inj_v = v;
        @(posedge CLK);
        @(negedge CLK);
        inj = 1'b0;
    endtask

    task automatic host_op(input logic we, input logic [ABITS-1:0] a,
                           input logic [BITS-1:0] d, input int clr_edge,
                           output int lat, output logic [BITS-1:0] rd,
                           output int pulses);
        bit got;
        got = 1'b0; lat = 0; pulses = 0; rd = '0;
        HREQ = 1'b1; HWE = we; HADDR = a; HWDATA = d;
        for (int k = 1; k <= 40 && !got; k++) begin
            ERR_CLR = (k == clr_edge);
            @(posedge CLK);
            @(negedge CLK);
            if (ERR_PULSE) pulses++;
            if (HACK) begin
                got = 1'b1; lat = k; rd = HRDATA; HREQ = 1'b0;
            end
        end
        ERR_CLR = 1'b0;
        HREQ = 1'b0;
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL host_timeout addr=%0h: no HACK, need one in 40 cycles", a);
        end
        repeat (3) begin
            @(posedge CLK);
            @(negedge CLK);
            if (ERR_PULSE) pulses++;
        end
    endtask

    task automatic test_reset();
        RST = 1'b1; HREQ = 0; HWE = 0; HADDR = '0; HWDATA = '0;
        SCRUB_EN = 0; ERR_CLR = 0; inj = 0; inj_blk = 0; inj_a = '0; inj_v = '0;
        repeat (2) @(negedge CLK);
        checks++;
        if ({HACK, RWE, ERR_PULSE, SCRUB_WRAP} !== 4'b0) begin
            errors++;
            $display("FAIL reset_pulses got=%b need=0000",
                     {HACK, RWE, ERR_PULSE, SCRUB_WRAP});
        end
        checks++;
        if ({HRDATA, RWDATA, RADDR, ERR_CNT} !== '0) begin
            errors++;
            $display("FAIL reset_data hrdata=%h rwdata=%h raddr=%h cnt=%0d need 0",
                     HRDATA, RWDATA, RADDR, ERR_CNT);
        end
        RST = 1'b0;
        errcnt_exp = 0;
        repeat (2) @(negedge CLK);
        for (int i = 0; i < N; i++) begin
            golden[i] = BITS'($urandom);
            corrupt(2'd3, ABITS'(i), golden[i]);
        end
    endtask

    task automatic test_write_read();
        int lat, p;
        logic [BITS-1:0] rd;
        host_op(1'b1, 5'h12, 8'hA5, 0, lat, rd, p);
        golden[5'h12] = 8'hA5;
        checks++;
        if (lat != 2) begin
            errors++;
            $display("FAIL write_latency got=%0d need=2", lat);
        end
        checks++;
        if ({memA[5'h12], memB[5'h12], memC[5'h12]} !== {3{8'hA5}}) begin
            errors++;
            $display("FAIL write_landed got=%h/%h/%h need=a5",
                     memA[5'h12], memB[5'h12], memC[5'h12]);
        end
        host_op(1'b0, 5'h12, 8'h00, 0, lat, rd, p);
        checks++;
        if (lat != 3 || rd !== 8'hA5 || p != 0) begin
            errors++;
            $display("FAIL clean_read lat=%0d rd=%h pulses=%0d need 3/a5/0", lat, rd, p);
        end
        checks++;
        if (ERR_CNT !== 8'(errcnt_exp)) begin
            errors++;
            $display("FAIL clean_errcnt got=%0d need=%0d", ERR_CNT, errcnt_exp);
        end
    endtask

    task automatic test_correct();
        int lat, p;
        logic [BITS-1:0] rd;
        corrupt(2'd1, 5'h12, 8'h5A);
        host_op(1'b0, 5'h12, 8'h00, 0, lat, rd, p);
        errcnt_exp = err_step(errcnt_exp);
        checks++;
        if (lat != 3 || rd !== 8'hA5 || p != 1) begin
            errors++;
            $display("FAIL corr_read lat=%0d rd=%h pulses=%0d need 3/a5/1", lat, rd, p);
        end
        checks++;
        if (ERR_CNT !== 8'd1) begin
            errors++;
            $display("FAIL corr_errcnt got=%0d need=1", ERR_CNT);
        end
        checks++;
        if (memB[5'h12] !== 8'hA5 || memA[5'h12] !== 8'hA5) begin
            errors++;
            $display("FAIL corr_writeback memB=%h memA=%h need=a5",
                     memB[5'h12], memA[5'h12]);
        end
    endtask

    task automatic test_random_host();
        int lat, p, exp_p;
        logic [BITS-1:0] rd, d, m;
        logic [ABITS-1:0] a;
        for (int i = 0; i < 24; i++) begin
            a = ABITS'($urandom);
            if ($urandom_range(0, 2) == 0) begin
                d = BITS'($urandom);
                host_op(1'b1, a, d, 0, lat, rd, p);
                golden[a] = d;
                checks++;
                if (lat != 2) begin
                    errors++;
                    $display("FAIL rnd_write lat=%0d need=2", lat);
                end
            end else begin
                exp_p = 0;
                if ($urandom_range(0, 1) == 1) begin
                    m = BITS'($urandom_range(1, 255));
                    corrupt(2'($urandom_range(0, 2)), a, golden[a] ^ m);
                    exp_p = 1;
                    errcnt_exp = err_step(errcnt_exp);
                end
                host_op(1'b0, a, 8'h00, 0, lat, rd, p);
                checks++;
                if (lat != 3 || rd !== golden[a] || p != exp_p) begin
                    errors++;
                    $display("FAIL rnd_read a=%h lat=%0d rd=%h p=%0d need 3/%h/%0d",
                             a, lat, rd, p, golden[a], exp_p);
                end
                checks++;
                if (ERR_CNT !== 8'(errcnt_exp)) begin
                    errors++;
                    $display("FAIL rnd_errcnt got=%0d need=%0d", ERR_CNT, errcnt_exp);
                end
            end
        end
    endtask

    task automatic test_saturate();
        int lat, p;
        logic [BITS-1:0] rd;
        for (int i = 0; i < 256; i++) begin
            corrupt(2'd1, 5'h03, golden[3] ^ 8'h01);
            host_op(1'b0, 5'h03, 8'h00, 0, lat, rd, p);
            errcnt_exp = err_step(errcnt_exp);
        end
        checks++;
        if (ERR_CNT !== 8'(errcnt_exp) || errcnt_exp != 255) begin
            errors++;
            $display("FAIL sat_reach got=%0d need=255", ERR_CNT);
        end
        corrupt(2'd2, 5'h03, golden[3] ^ 8'h80);
        host_op(1'b0, 5'h03, 8'h00, 0, lat, rd, p);
        checks++;
        if (ERR_CNT !== 8'd255 || p != 1 || rd !== golden[3]) begin
            errors++;
            $display("FAIL sat_hold cnt=%0d p=%0d rd=%h need 255/1/%h",
                     ERR_CNT, p, rd, golden[3]);
        end
        corrupt(2'd0, 5'h07, ~golden[7]);
        host_op(1'b0, 5'h07, 8'h00, 3, lat, rd, p);
        errcnt_exp = 0;
        checks++;
        if (ERR_CNT !== 8'd0 || p != 1) begin
            errors++;
            $display("FAIL clr_vs_inc cnt=%0d p=%0d need 0/1", ERR_CNT, p);
        end
    endtask

    task automatic run_sweep(input bit hold_host, input logic [ABITS-1:0] haddr,
                             output int wraps, output int hacks, output int pulses,
                             output int wbn, output logic [ABITS-1:0] wbq [$],
                             output bit seen_all);
        bit seen [N];
        wraps = 0; hacks = 0; pulses = 0; wbn = 0;
        wbq = {};
        for (int i = 0; i < N; i++) seen[i] = 1'b0;
        if (hold_host) begin
            HREQ = 1'b1; HWE = 1'b1; HADDR = haddr; HWDATA = golden[haddr];
        end
        SCRUB_EN = 1'b1;
        for (int c = 0; c < 3000 && wraps == 0; c++) begin
            @(posedge CLK);
            @(negedge CLK);
            if (!hold_host || RADDR != haddr) seen[RADDR] = 1'b1;
            if (HACK) hacks++;
            if (ERR_PULSE) pulses++;
            if (RWE && !(hold_host && RADDR == haddr)) begin
                wbq.push_back(RADDR);
                wbn++;
            end
            if (SCRUB_WRAP) wraps++;
        end
        HREQ = 1'b0;
        SCRUB_EN = 1'b0;
        repeat (6) @(negedge CLK);
        seen_all = 1'b1;
        for (int i = 0; i < N; i++) if (!seen[i]) seen_all = 1'b0;
    endtask

    task automatic test_scrub();
        int wraps, hacks, p, wbn, lat, rp;
        logic [ABITS-1:0] wbq [$];
        logic [BITS-1:0] rd;
        bit seen_all;
        corrupt(2'd2, 5'd2, ~golden[2]);
        corrupt(2'd0, 5'd17, golden[17] ^ 8'h10);
        run_sweep(1'b0, '0, wraps, hacks, p, wbn, wbq, seen_all);
        errcnt_exp = err_step(err_step(errcnt_exp));
        checks++;
        if (wraps != 1 || !seen_all) begin
            errors++;
            $display("FAIL scrub_wrap wraps=%0d seen_all=%0d need 1/1", wraps, seen_all);
        end
        checks++;
        if (wbn != 2 || p != 2) begin
            errors++;
            $display("FAIL scrub_wb_count wb=%0d pulses=%0d need 2/2", wbn, p);
        end else begin
            checks++;
            if (wbq[0] != 5'd2 || wbq[1] != 5'd17) begin
                errors++;
                $display("FAIL scrub_wb_addr got=%0d,%0d need=2,17", wbq[0], wbq[1]);
            end
        end
        checks++;
        if (ERR_CNT !== 8'(errcnt_exp)) begin
            errors++;
            $display("FAIL scrub_errcnt got=%0d need=%0d", ERR_CNT, errcnt_exp);
        end
        host_op(1'b0, 5'd2, 8'h00, 0, lat, rd, rp);
        checks++;
        if (rd !== golden[2] || rp != 0) begin
            errors++;
            $display("FAIL scrub_fixed rd=%h p=%0d need %h/0", rd, rp, golden[2]);
        end
    endtask

    task automatic test_back_to_back();
        int wraps, hacks, p, wbn;
        logic [ABITS-1:0] wbq [$];
        bit seen_all;
        corrupt(2'd1, 5'd9, golden[9] ^ 8'hC3);
        run_sweep(1'b1, 5'd20, wraps, hacks, p, wbn, wbq, seen_all);
        errcnt_exp = err_step(errcnt_exp);
        checks++;
        if (wraps != 1) begin
            errors++;
            $display("FAIL alt_scrub_progress wraps=%0d need=1", wraps);
        end
        checks++;
        if (hacks < 30) begin
            errors++;
            $display("FAIL alt_host_share hacks=%0d need>=30", hacks);
        end
        checks++;
        if (wbn != 1 || p != 1) begin
            errors++;
            $display("FAIL alt_wb wb=%0d pulses=%0d need 1/1", wbn, p);
        end else begin
            checks++;
            if (wbq[0] != 5'd9) begin
                errors++;
                $display("FAIL alt_wb_addr got=%0d need=9", wbq[0]);
            end
        end
        checks++;
        if (ERR_CNT !== 8'(errcnt_exp)) begin
            errors++;
            $display("FAIL alt_errcnt got=%0d need=%0d", ERR_CNT, errcnt_exp);
        end
    endtask

    task automatic test_reset_in_wb();
        int lat, p;
        logic [BITS-1:0] rd;
        bit found;
        found = 1'b0;
        corrupt(2'd1, 5'd5, golden[5] ^ 8'h3C);
        HREQ = 1'b1; HWE = 1'b0; HADDR = 5'd5;
        for (int k = 0; k < 10 && !found; k++) begin
            @(posedge CLK);
            @(negedge CLK);
            if (RWE && ERR_PULSE) found = 1'b1;
        end
        HREQ = 1'b0;
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL rstwb_reach got no WB cycle, need one");
        end
        RST = 1'b1;
        #1;
        checks++;
        if ({RWE, HACK, ERR_PULSE, SCRUB_WRAP} !== 4'b0 ||
            {HRDATA, RWDATA, RADDR, ERR_CNT} !== '0) begin
            errors++;
            $display("FAIL rstwb_outputs rwe=%b hack=%b ep=%b rd=%h wd=%h a=%h c=%0d need 0",
                     RWE, HACK, ERR_PULSE, HRDATA, RWDATA, RADDR, ERR_CNT);
        end
        @(negedge CLK);
        RST = 1'b0;
        errcnt_exp = 0;
        @(negedge CLK);
        corrupt(2'd3, 5'd5, golden[5]);
        host_op(1'b0, 5'd5, 8'h00, 0, lat, rd, p);
        checks++;
        if (lat != 3 || rd !== golden[5] || p != 0 || ERR_CNT !== 8'd0) begin
            errors++;
            $display("FAIL rstwb_after lat=%0d rd=%h p=%0d c=%0d need 3/%h/0/0",
                     lat, rd, p, ERR_CNT, golden[5]);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_correct();
        test_random_host();
        test_saturate();
        test_scrub();
        test_back_to_back();
        test_reset_in_wb();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
